// File: rtl/frame_peak_detector.sv
// ---------------------------------------------------------------------------
// frame_peak_detector
//
// Splits a stream of signed samples into frames of a runtime-selectable
// number of valid samples. For each frame it reports the maximum, the
// minimum, the peak-to-peak amplitude and the 0-based in-frame index of the
// first occurrence of each extremum, as a one-cycle result pulse.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   i_data       signed input sample, qualified by i_valid
//   i_valid      sample strobe (gaps allowed)
//   i_frame_len  samples per frame (0 behaves as 1), latched at frame start
//   i_clear      abort the current partial frame
//   o_max        signed frame maximum
//   o_min        signed frame minimum
//   o_pp         unsigned o_max - o_min, one bit wider than the samples
//   o_max_idx    index of the first occurrence of the maximum
//   o_min_idx    index of the first occurrence of the minimum
//   o_valid      one-cycle pulse; result outputs update in the same cycle
// ---------------------------------------------------------------------------
module frame_peak_detector #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic [LEN_WIDTH-1:0]  i_frame_len,
    input  logic                  i_clear,
    output logic [DATA_WIDTH-1:0] o_max,
    output logic [DATA_WIDTH-1:0] o_min,
    output logic [DATA_WIDTH:0]   o_pp,
    output logic [LEN_WIDTH-1:0]  o_max_idx,
    output logic [LEN_WIDTH-1:0]  o_min_idx,
    output logic                  o_valid
);

    // Frame bookkeeping
    logic [LEN_WIDTH-1:0]  cnt;
    logic [LEN_WIDTH-1:0]  len_q;

    // Running extrema of the frame in progress
    logic [DATA_WIDTH-1:0] run_max;
    logic [DATA_WIDTH-1:0] run_min;
    logic [LEN_WIDTH-1:0]  run_max_idx;
    logic [LEN_WIDTH-1:0]  run_min_idx;

    // Frame closed on the previous edge; result stage fires on this one
    logic                  done_q;

    // Combinational helpers
    logic                  first;
    logic [LEN_WIDTH-1:0]  len_in;
    logic [LEN_WIDTH-1:0]  len_eff;
    logic [LEN_WIDTH-1:0]  cnt_eff;
    logic                  last;
    logic                  gt_max;
    logic                  lt_min;
    logic [DATA_WIDTH:0]   pp_next;

    always_comb begin
        // A clear with a valid sample restarts the frame on that sample, so
        // it is handled exactly like the first sample of a fresh frame.
        first   = i_clear || (cnt == '0);
        len_in  = (i_frame_len == '0) ? LEN_WIDTH'(1) : i_frame_len;
        len_eff = first ? len_in : len_q;
        cnt_eff = first ? '0 : cnt;
        last    = (cnt_eff == len_eff - LEN_WIDTH'(1));
        gt_max  = $signed(i_data) > $signed(run_max);
        lt_min  = $signed(i_data) < $signed(run_min);
        // Sign-extend both operands by one bit; the difference of max and
        // min is never negative, so the wider result reads as unsigned.
        pp_next = {run_max[DATA_WIDTH-1], run_max} - {run_min[DATA_WIDTH-1], run_min};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            len_q       <= '0;
            run_max     <= '0;
            run_min     <= '0;
            run_max_idx <= '0;
            run_min_idx <= '0;
            done_q      <= 1'b0;
            o_max       <= '0;
            o_min       <= '0;
            o_pp        <= '0;
            o_max_idx   <= '0;
            o_min_idx   <= '0;
            o_valid     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (i_valid) begin
                if (first) begin
                    len_q       <= len_in;
                    run_max     <= i_data;
                    run_min     <= i_data;
                    run_max_idx <= '0;
                    run_min_idx <= '0;
                end else begin
                    // Strict compares keep the earlier index on ties.
                    if (gt_max) begin
                        run_max     <= i_data;
                        run_max_idx <= cnt;
                    end
                    if (lt_min) begin
                        run_min     <= i_data;
                        run_min_idx <= cnt;
                    end
                end
                cnt    <= last ? '0 : cnt_eff + LEN_WIDTH'(1);
                // A clear on the would-be closing sample suppresses the result.
                done_q <= last && !i_clear;
            end else if (i_clear) begin
                cnt <= '0;
            end

            // NOTE: non-blocking assignments make the result stage read the
            // running registers as they were before this edge, so a new
            // frame's first sample arriving now cannot corrupt the result.
            o_valid <= done_q;
            if (done_q) begin
                o_max     <= run_max;
                o_min     <= run_min;
                o_pp      <= pp_next;
                o_max_idx <= run_max_idx;
                o_min_idx <= run_min_idx;
            end
        end
    end

endmodule

// File: tb/tb_frame_peak_detector.sv
// ---------------------------------------------------------------------------
// tb_frame_peak_detector
//
// Directed self-checking bench for frame_peak_detector. Inputs are driven on
// the falling edge; a monitor records every o_valid pulse (values plus the
// rising-edge count at which it became visible) on the falling edge, and the
// directed tests compare those records against hand-computed values.
// ---------------------------------------------------------------------------
module tb_frame_peak_detector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] i_data;
    logic        i_valid;
    logic [15:0] i_frame_len;
    logic        i_clear;
    logic [15:0] o_max;
    logic [15:0] o_min;
    logic [16:0] o_pp;
    logic [15:0] o_max_idx;
    logic [15:0] o_min_idx;
    logic        o_valid;

    frame_peak_detector #(.DATA_WIDTH(16), .LEN_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .i_frame_len (i_frame_len),
        .i_clear     (i_clear),
        .o_max       (o_max),
        .o_min       (o_min),
        .o_pp        (o_pp),
        .o_max_idx   (o_max_idx),
        .o_min_idx   (o_min_idx),
        .o_valid     (o_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] mx;
        logic [15:0] mn;
        logic [16:0] pp;
        logic [15:0] mxi;
        logic [15:0] mni;
        int          cyc;
    } pulse_t;

    pulse_t pulses[$];
    int     cyc      = 0;
    int     last_cyc = 0;
    int     n_checks = 0;
    int     n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_valid) begin
            pulses.push_back('{o_max, o_min, o_pp, o_max_idx, o_min_idx, cyc});
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] s16(input int v);
        s16 = {16'h0, v[15:0]};
    endfunction

    // One clock of stimulus; last_cyc holds the edge number that sampled it.
    task automatic send(input int d, input bit v, input bit c);
        @(negedge clk);
        i_data  = d[15:0];
        i_valid = v;
        i_clear = c;
        @(posedge clk);
        #1;
        last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(0, 1'b0, 1'b0);
    endtask

    task automatic expect_pulse(input string tag, input int mx, input int mn, input int pp,
                                input int mxi, input int mni, input int ecyc);
        pulse_t r;
        if (pulses.size() == 0) begin
            check({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            r = pulses.pop_front();
            check({tag, "_max"},     {16'h0, r.mx},  s16(mx));
            check({tag, "_min"},     {16'h0, r.mn},  s16(mn));
            check({tag, "_pp"},      {15'h0, r.pp},  32'(pp));
            check({tag, "_max_idx"}, {16'h0, r.mxi}, 32'(mxi));
            check({tag, "_min_idx"}, {16'h0, r.mni}, 32'(mni));
            check({tag, "_cycle"},   32'(r.cyc),     32'(ecyc));
        end
    endtask

    task automatic expect_none(input string tag);
        check({tag, "_extra_pulses"}, 32'(pulses.size()), 32'd0);
        pulses.delete();
    endtask

    int c1;

    initial begin
        rst_n       = 1'b0;
        i_data      = '0;
        i_valid     = 1'b0;
        i_clear     = 1'b0;
        i_frame_len = 16'd4;
        idle(2);

        // Reset mid-frame with samples streaming in
        rst_n = 1'b1;
        send(11, 1'b1, 1'b0);
        send(22, 1'b1, 1'b0);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) send(int'($urandom_range(0, 65535)), 1'b1, 1'b0);
        check("rst_max",     {16'h0, o_max},     32'd0);
        check("rst_min",     {16'h0, o_min},     32'd0);
        check("rst_pp",      {15'h0, o_pp},      32'd0);
        check("rst_max_idx", {16'h0, o_max_idx}, 32'd0);
        check("rst_min_idx", {16'h0, o_min_idx}, 32'd0);
        check("rst_valid",   {31'h0, o_valid},   32'd0);
        expect_none("rst");
        rst_n = 1'b1;

        // Basic frame: the partial frame before reset must not count
        send(3, 1'b1, 1'b0);
        send(-5, 1'b1, 1'b0);
        send(7, 1'b1, 1'b0);
        send(7, 1'b1, 1'b0);
        c1 = last_cyc;
        idle(4);
        expect_pulse("basic", 7, -5, 12, 2, 1, c1 + 1);
        expect_none("basic");
        check("hold_max",   {16'h0, o_max},   s16(7));
        check("hold_valid", {31'h0, o_valid}, 32'd0);

        // Full-scale swing
        i_frame_len = 16'd2;
        send(32767, 1'b1, 1'b0);
        send(-32768, 1'b1, 1'b0);
        c1 = last_cyc;
        idle(3);
        expect_pulse("full", 32767, -32768, 65535, 0, 1, c1 + 1);
        expect_none("full");

        // Back-to-back, continuous valid
        i_frame_len = 16'd3;
        send(1, 1'b1, 1'b0);
        send(2, 1'b1, 1'b0);
        send(3, 1'b1, 1'b0);
        c1 = last_cyc;
        send(-1, 1'b1, 1'b0);
        send(-2, 1'b1, 1'b0);
        send(-3, 1'b1, 1'b0);
        idle(3);
        expect_pulse("b2b_a", 3, 1, 2, 2, 0, c1 + 1);
        expect_pulse("b2b_b", -1, -3, 2, 0, 2, c1 + 4);
        expect_none("b2b");

        // Back-to-back with valid deasserted every other cycle
        send(1, 1'b1, 1'b0); idle(1);
        send(2, 1'b1, 1'b0); idle(1);
        send(3, 1'b1, 1'b0);
        c1 = last_cyc;
        idle(1);
        send(-1, 1'b1, 1'b0); idle(1);
        send(-2, 1'b1, 1'b0); idle(1);
        send(-3, 1'b1, 1'b0);
        idle(3);
        expect_pulse("gap_a", 3, 1, 2, 2, 0, c1 + 1);
        expect_pulse("gap_b", -1, -3, 2, 0, 2, c1 + 7);
        expect_none("gap");

        // Clear alone aborts the partial frame
        i_frame_len = 16'd4;
        send(100, 1'b1, 1'b0);
        send(200, 1'b1, 1'b0);
        send(0, 1'b0, 1'b1);
        send(1, 1'b1, 1'b0);
        send(2, 1'b1, 1'b0);
        send(3, 1'b1, 1'b0);
        send(4, 1'b1, 1'b0);
        c1 = last_cyc;
        idle(3);
        expect_pulse("clr", 4, 1, 3, 3, 0, c1 + 1);
        expect_none("clr");

        // Clear on the closing sample: no pulse, sample opens the next frame
        send(10, 1'b1, 1'b0);
        send(20, 1'b1, 1'b0);
        send(30, 1'b1, 1'b0);
        send(40, 1'b1, 1'b1);
        idle(3);
        expect_none("clr_last_nopulse");
        send(41, 1'b1, 1'b0);
        send(42, 1'b1, 1'b0);
        send(43, 1'b1, 1'b0);
        c1 = last_cyc;
        idle(3);
        expect_pulse("clr_last", 43, 40, 3, 3, 0, c1 + 1);
        expect_none("clr_last");

        // Clear right after a closing sample does not cancel its result
        i_frame_len = 16'd2;
        send(6, 1'b1, 1'b0);
        send(7, 1'b1, 1'b0);
        c1 = last_cyc;
        send(0, 1'b0, 1'b1);
        idle(2);
        expect_pulse("clr_pend", 7, 6, 1, 1, 0, c1 + 1);
        expect_none("clr_pend");

        // Frame length 0 and 1 both close on every sample
        i_frame_len = 16'd0;
        send(5, 1'b1, 1'b0);
        c1 = last_cyc;
        send(-9, 1'b1, 1'b0);
        idle(3);
        expect_pulse("len0_a", 5, 5, 0, 0, 0, c1 + 1);
        expect_pulse("len0_b", -9, -9, 0, 0, 0, c1 + 2);
        expect_none("len0");
        i_frame_len = 16'd1;
        send(5, 1'b1, 1'b0);
        c1 = last_cyc;
        send(-9, 1'b1, 1'b0);
        idle(3);
        expect_pulse("len1_a", 5, 5, 0, 0, 0, c1 + 1);
        expect_pulse("len1_b", -9, -9, 0, 0, 0, c1 + 2);
        expect_none("len1");

        // Length change mid-frame takes effect only at the next frame
        i_frame_len = 16'd4;
        send(1, 1'b1, 1'b0);
        i_frame_len = 16'd2;
        send(2, 1'b1, 1'b0);
        send(3, 1'b1, 1'b0);
        idle(2);
        expect_none("lenchg_early");
        send(4, 1'b1, 1'b0);
        c1 = last_cyc;
        send(9, 1'b1, 1'b0);
        send(8, 1'b1, 1'b0);
        idle(3);
        expect_pulse("lenchg_a", 4, 1, 3, 3, 0, c1 + 1);
        expect_pulse("lenchg_b", 9, 8, 1, 0, 1, c1 + 3);
        expect_none("lenchg");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
